// File: rtl/avg_decimator_pkg.sv
// Shared handshake state encodings and parameter checks for the averaging decimator
// and the push-port stages built around it.
package avg_decimator_pkg;

  typedef enum logic [1:0] {
    I_REQ  = 2'd0,
    I_RET  = 2'd1,
    I_HOLD = 2'd2
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_RET  = 2'd2
  } out_state_e;

  localparam int LOG2R_MAX = 8;

  function automatic bit log2r_legal(input int log2r);
    return (log2r >= 0) && (log2r <= LOG2R_MAX);
  endfunction

endpackage

// File: rtl/hs_push_port.sv
// One-entry output slot driving a 4-phase push handshake; data_out changes only when
// a new value is loaded into the empty slot.
module hs_push_port
  import avg_decimator_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [0:DWIDTH-1] load_data,
  output logic              load_ready,
  output logic              req_out,
  input  logic              ack_out,
  output logic [0:DWIDTH-1] data_out
);

  out_state_e        state_r;
  logic              req_out_r;
  logic              out_full_r;
  logic [0:DWIDTH-1] data_out_r;
  logic              load_take_s;
  logic              free_s;

  // Slot accepts only when empty; it is freed by the sink's acknowledge.
  always_comb begin
    load_take_s = load_valid && !out_full_r;
    free_s      = (state_r == O_REQ) && ack_out;
  end

  // OUT slot occupancy and held output data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_full_r <= 1'b0;
      data_out_r <= '0;
    end else begin
      if (load_take_s) begin
        out_full_r <= 1'b1;
        data_out_r <= load_data;
      end else if (free_s) begin
        out_full_r <= 1'b0;
      end else begin
        out_full_r <= out_full_r;
      end
    end
  end

  // Output FSM; a load into the idle port raises req_out on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= O_IDLE;
      req_out_r <= 1'b0;
    end else begin
      case (state_r)
        O_IDLE: begin
          if ((out_full_r || load_take_s) && !ack_out) begin
            state_r   <= O_REQ;
            req_out_r <= 1'b1;
          end else begin
            state_r   <= O_IDLE;
            req_out_r <= 1'b0;
          end
        end
        O_REQ: begin
          if (ack_out) begin
            state_r   <= O_RET;
            req_out_r <= 1'b0;
          end else begin
            state_r   <= O_REQ;
            req_out_r <= 1'b1;
          end
        end
        O_RET: begin
          req_out_r <= 1'b0;
          if (!ack_out) begin
            state_r <= O_IDLE;
          end else begin
            state_r <= O_RET;
          end
        end
        default: begin
          state_r   <= O_IDLE;
          req_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = !out_full_r;
  assign req_out    = req_out_r;
  assign data_out   = data_out_r;

endmodule

// File: rtl/avg_decimator.sv
// Boxcar-average decimator: pulls signed samples over a 4-phase handshake and pushes
// one rounded (or floored) average per block of 2^LOG2R samples.
module avg_decimator
  import avg_decimator_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int LOG2R  = 2,
  parameter int ROUND  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     req_in,
  input  logic                     ack_in,
  input  logic signed [0:DWIDTH-1] data_in,
  output logic                     req_out,
  input  logic                     ack_out,
  output logic signed [0:DWIDTH-1] data_out
);

  localparam int AW  = DWIDTH + LOG2R;
  localparam int CW  = LOG2R + 1;
  localparam int R   = 1 << LOG2R;
  localparam int RND = (ROUND != 0 && LOG2R > 0) ? (1 << ((LOG2R > 0) ? LOG2R - 1 : 0)) : 0;

  if (!log2r_legal(LOG2R)) begin : g_bad_log2r
    $error("avg_decimator: LOG2R must be in 0..8");
  end

  in_state_e                in_state_r;
  logic                     req_in_r;
  logic signed [AW-1:0]     acc_r;
  logic        [CW-1:0]     cnt_r;
  logic        [0:DWIDTH-1] sum_r;
  logic                     sum_valid_r;

  logic                     capture_s;
  logic                     block_end_s;
  logic signed [AW:0]       sum_wide_s;
  logic        [0:DWIDTH-1] avg_s;
  logic                     load_ready_s;
  logic                     move_s;
  logic                     sum_valid_next_s;

  // Block-end arithmetic; the widened sum cannot overflow and the shifted result fits DWIDTH.
  always_comb begin
    capture_s        = (in_state_r == I_REQ) && ack_in;
    block_end_s      = capture_s && (cnt_r == CW'(R - 1));
    sum_wide_s       = (AW+1)'(acc_r) + (AW+1)'(data_in) + (AW+1)'(RND);
    avg_s            = DWIDTH'(sum_wide_s >>> LOG2R);
    move_s           = sum_valid_r && load_ready_s;
    sum_valid_next_s = block_end_s ? 1'b1 : (move_s ? 1'b0 : sum_valid_r);
  end

  // Accumulator and in-block sample counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (block_end_s) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (capture_s) begin
      acc_r <= acc_r + AW'(data_in);
      cnt_r <= cnt_r + CW'(1);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // SUM slot: loaded at block end, freed when handed to the output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r       <= '0;
      sum_valid_r <= 1'b0;
    end else begin
      sum_valid_r <= sum_valid_next_s;
      if (block_end_s) begin
        sum_r <= avg_s;
      end else begin
        sum_r <= sum_r;
      end
    end
  end

  // Input FSM; reset parks in I_HOLD so req_in rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_r <= I_HOLD;
      req_in_r   <= 1'b0;
    end else begin
      case (in_state_r)
        I_REQ: begin
          if (ack_in) begin
            in_state_r <= I_RET;
            req_in_r   <= 1'b0;
          end else begin
            in_state_r <= I_REQ;
            req_in_r   <= 1'b1;
          end
        end
        I_RET: begin
          if (!ack_in && sum_valid_next_s) begin
            in_state_r <= I_HOLD;
            req_in_r   <= 1'b0;
          end else if (!ack_in) begin
            in_state_r <= I_REQ;
            req_in_r   <= 1'b1;
          end else begin
            in_state_r <= I_RET;
            req_in_r   <= 1'b0;
          end
        end
        I_HOLD: begin
          if (!sum_valid_r) begin
            in_state_r <= I_REQ;
            req_in_r   <= 1'b1;
          end else begin
            in_state_r <= I_HOLD;
            req_in_r   <= 1'b0;
          end
        end
        default: begin
          in_state_r <= I_HOLD;
          req_in_r   <= 1'b0;
        end
      endcase
    end
  end

  hs_push_port #(
    .DWIDTH(DWIDTH)
  ) u_push (
    .clk       (clk),
    .rst       (rst),
    .load_valid(sum_valid_r),
    .load_data (sum_r),
    .load_ready(load_ready_s),
    .req_out   (req_out),
    .ack_out   (ack_out),
    .data_out  (data_out)
  );

  assign req_in = req_in_r;

endmodule
